nibble_serial_sub: RTL and testbench
====================================

NIBBLE_SERIAL_SUB -- requirements
Module: nibble_serial_sub

Interface
REQ-001 Parameter: WIDTH, default 16, operand/result width in bits; SHALL be a multiple of 4 and at least 8.
REQ-002 Derived constant: NIB = WIDTH/4, the number of 4-bit slices processed per operation.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  operand pair a/b is offered.
REQ-006 in_ready  output  1  block can accept an operand pair.
REQ-007 a  input  WIDTH  minuend.
REQ-008 b  input  WIDTH  subtrahend.
REQ-009 out_valid  output  1  diff/borrow are valid.
REQ-010 out_ready  input  1  consumer accepts the result.
REQ-011 diff  output  WIDTH  a - b modulo 2^WIDTH.
REQ-012 borrow  output  1  unsigned borrow out; 1 iff a < b unsigned.
REQ-013 ovf  output  1  signed two's-complement overflow (present only with SUB_SIGNED_OVF_EN).

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-015 in_ready SHALL be 1 in IDLE and 0 in RUN and DONE.
REQ-016 Acceptance occurs on an edge where in_valid=1 and in_ready=1: a and b are captured, the slice counter is cleared to 0, the carry register is set to 1, and the state moves to RUN.
REQ-017 Each RUN cycle, slice k computes a[4k+3:4k] + ~b[4k+3:4k] + carry with 4-bit lookahead, writes the 4-bit result to diff[4k+3:4k], stores the carry-out, and increments k.
REQ-018 After slice NIB-1 the state SHALL move to DONE with out_valid=1; out_valid therefore rises exactly NIB cycles after the acceptance edge (4 cycles for WIDTH=16).
REQ-019 borrow SHALL be the inverse of the final carry-out.
REQ-020 In DONE, diff/borrow/ovf SHALL hold stable until an edge where out_ready=1; that edge returns the state to IDLE and clears out_valid.
REQ-021 in_valid asserted while in RUN or DONE SHALL be ignored, with no capture and no effect on the result.
REQ-022 out_ready asserted outside DONE SHALL have no effect.
REQ-023 Captured operands SHALL be internal registers, so changes on a/b after acceptance do not affect the result.
REQ-024 diff bits of slices not yet computed are don't-care while out_valid=0.

Reset
REQ-025 While rst_n=0 the block SHALL be in IDLE with in_ready=1, out_valid=0, diff=0, borrow=0, ovf=0, counter=0 and carry=1.
REQ-026 Reset asserted mid-RUN or in DONE SHALL abort the operation immediately; no result is delivered.
REQ-027 After rst_n deasserts, the first acceptance SHALL be possible on the first clock edge.

Configuration
REQ-028 Macro SUB_SIGNED_OVF_EN: when defined, the ovf port exists and equals (a[MSB]!=b[MSB]) && (diff[MSB]!=a[MSB]) on the captured operands, valid with out_valid.
REQ-029 When SUB_SIGNED_OVF_EN is undefined, the ovf port and its logic SHALL be absent; all other behaviour is unchanged.

Structure
REQ-030 A shared package sub_pkg SHALL hold the slice width constant SLICE_W=4 and the FSM state enumeration type.
REQ-031 One sub-module, sub_slice, SHALL implement the 4-bit lookahead slice: inputs x[3:0], y[3:0] (already inverted) and cin; outputs s[3:0] and cout, with carries from generate/propagate terms.
REQ-032 nibble_serial_sub SHALL instantiate exactly one sub_slice, time-multiplexed across all slices.

Verification (WIDTH=16)
REQ-033 a=0x1234, b=0x0034 -> after 4 cycles out_valid=1, diff=0x1200, borrow=0, ovf=0.
REQ-034 a=0x0000, b=0x0001 -> diff=0xFFFF, borrow=1, ovf=0.
REQ-035 a=0x8000, b=0x0001 -> diff=0x7FFF, borrow=0, ovf=1 (with macro); with macro undefined, diff and borrow are identical.
REQ-036 Hold out_ready=0 for 10 cycles after out_valid, then change a/b and pulse in_valid -> diff stays stable and in_ready=0 throughout; on the out_ready edge the block returns to IDLE.
REQ-037 Accept a=0xFFFF, b=0x0F0F and pull rst_n low in cycle 2 of RUN -> immediately out_valid=0 and in_ready=1; a following a=0x0005, b=0x0003 yields diff=0x0002, borrow=0.
REQ-038 Back-to-back ops with out_ready tied 1 and in_valid tied 1 -> one result every NIB+2 cycles, each correct against a reference model.

Source files
------------

// File: rtl/sub_pkg.sv
// rtl/sub_pkg.sv - shared slice width and FSM state type for the nibble-serial subtractor
package sub_pkg;
  localparam int SLICE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/nibble_serial_sub_if.sv
// rtl/nibble_serial_sub_if.sv - operand/result handshake bundle; ovf present with SUB_SIGNED_OVF_EN
interface nibble_serial_sub_if #(parameter int WIDTH = 16);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             borrow;
`ifdef SUB_SIGNED_OVF_EN
  logic             ovf;
`endif

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, diff, borrow
`ifdef SUB_SIGNED_OVF_EN
    , input ovf
`endif
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, diff, borrow
`ifdef SUB_SIGNED_OVF_EN
    , output ovf
`endif
  );
endinterface

// File: rtl/sub_slice.sv
// rtl/sub_slice.sv - 4-bit carry-lookahead adder slice (y arrives already inverted)
module sub_slice
  import sub_pkg::*;
(
  input  logic [SLICE_W-1:0] x,
  input  logic [SLICE_W-1:0] y,
  input  logic               cin,
  output logic [SLICE_W-1:0] s,
  output logic               cout
);
  logic [SLICE_W-1:0] g;
  logic [SLICE_W-1:0] p;
  logic [SLICE_W:0]   c;

  assign g = x & y;
  assign p = x ^ y;

  // Every carry is flattened from generate/propagate terms, none rippled.
  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & cin);

  assign s    = p ^ c[SLICE_W-1:0];
  assign cout = c[SLICE_W];
endmodule

// File: rtl/nibble_serial_sub.sv
// rtl/nibble_serial_sub.sv - nibble-serial a-b subtractor; SUB_SIGNED_OVF_EN adds signed overflow
module nibble_serial_sub
  import sub_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  nibble_serial_sub_if.slave  bus
);
  localparam int NIB = WIDTH / SLICE_W;
  localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [CW-1:0] LAST = CW'(NIB - 1);

  state_t             state;
  logic [CW-1:0]      cnt;
  logic               carry;
  logic [WIDTH-1:0]   a_r;
  logic [WIDTH-1:0]   b_r;
  logic [WIDTH-1:0]   diff_r;
  logic               borrow_r;
  logic               in_ready_r;
  logic               out_valid_r;
  logic [SLICE_W-1:0] x;
  logic [SLICE_W-1:0] y;
  logic [SLICE_W-1:0] s;
  logic               cout;

  // a - b is formed as a + ~b + 1, so the carry chain starts at 1.
  assign x = a_r[int'(cnt)*SLICE_W +: SLICE_W];
  assign y = ~b_r[int'(cnt)*SLICE_W +: SLICE_W];

  sub_slice u_slice (
    .x    (x),
    .y    (y),
    .cin  (carry),
    .s    (s),
    .cout (cout)
  );

`ifdef SUB_SIGNED_OVF_EN
  logic ovf_r;
  assign bus.ovf = ovf_r;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      carry       <= 1'b1;
      a_r         <= '0;
      b_r         <= '0;
      diff_r      <= '0;
      borrow_r    <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
`ifdef SUB_SIGNED_OVF_EN
      ovf_r       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_r        <= bus.a;
            b_r        <= bus.b;
            cnt        <= '0;
            carry      <= 1'b1;
            in_ready_r <= 1'b0;
            state      <= RUN;
          end
        end
        RUN: begin
          diff_r[int'(cnt)*SLICE_W +: SLICE_W] <= s;
          carry <= cout;
          if (cnt == LAST) begin
            cnt         <= '0;
            borrow_r    <= ~cout;
            out_valid_r <= 1'b1;
            state       <= DONE;
`ifdef SUB_SIGNED_OVF_EN
            // s[SLICE_W-1] is the final diff MSB being written this cycle.
            ovf_r <= (a_r[WIDTH-1] != b_r[WIDTH-1]) && (s[SLICE_W-1] != a_r[WIDTH-1]);
`endif
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: begin
          state       <= IDLE;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.diff      = diff_r;
  assign bus.borrow    = borrow_r;
endmodule

// File: tb/tb_nibble_serial_sub.sv
// tb/tb_nibble_serial_sub.sv - directed self-checking bench for nibble_serial_sub (WIDTH=16)
module tb_nibble_serial_sub;
  localparam int WIDTH = 16;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  nibble_serial_sub_if #(.WIDTH(WIDTH)) bus_i ();

  nibble_serial_sub #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_ovf(input string tag, input logic exp);
`ifdef SUB_SIGNED_OVF_EN
    chk(tag, 32'(bus_i.ovf), 32'(exp));
`else
    if (exp === 1'bx) $display("unused %s", tag);
`endif
  endtask

  task automatic run_op(input logic [15:0] av, input logic [15:0] bv,
                        input logic [15:0] ed, input logic eb, input logic eo);
    int lat;
    chk("pre_in_ready", 32'(bus_i.in_ready), 32'd1);
    bus_i.a        = av;
    bus_i.b        = bv;
    bus_i.in_valid = 1'b1;
    tick();
    bus_i.in_valid = 1'b0;
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!bus_i.out_valid && lat < 20);
    chk("latency", 32'(lat), 32'd4);
    chk("diff", 32'(bus_i.diff), 32'(ed));
    chk("borrow", 32'(bus_i.borrow), 32'(eb));
    chk_ovf("ovf", eo);
    bus_i.out_ready = 1'b1;
    tick();
    bus_i.out_ready = 1'b0;
    chk("post_out_valid", 32'(bus_i.out_valid), 32'd0);
    chk("post_in_ready", 32'(bus_i.in_ready), 32'd1);
  endtask

  initial begin
    int          cyc;
    int          last;
    int          got;
    logic [16:0] ref_res;
    logic [15:0] va [4];
    logic [15:0] vb [4];

    n_vec = 0;
    n_err = 0;
    bus_i.in_valid  = 1'b0;
    bus_i.out_ready = 1'b0;
    bus_i.a         = '0;
    bus_i.b         = '0;

    rst_n = 1'b0;
    tick();
    tick();
    chk("rst_in_ready", 32'(bus_i.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus_i.out_valid), 32'd0);
    chk("rst_diff", 32'(bus_i.diff), 32'd0);
    chk("rst_borrow", 32'(bus_i.borrow), 32'd0);
    chk_ovf("rst_ovf", 1'b0);

    rst_n = 1'b1;
    run_op(16'h1234, 16'h0034, 16'h1200, 1'b0, 1'b0);
    run_op(16'h0000, 16'h0001, 16'hFFFF, 1'b1, 1'b0);
    run_op(16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b1);
    run_op(16'h5555, 16'h5555, 16'h0000, 1'b0, 1'b0);
    run_op(16'h0F0F, 16'hF0F0, 16'h1E1F, 1'b1, 1'b0);
    run_op(16'h7FFF, 16'hFFFF, 16'h8000, 1'b1, 1'b1);

    // Result must hold while the consumer stalls; new operands are ignored.
    bus_i.a        = 16'h1234;
    bus_i.b        = 16'h0034;
    bus_i.in_valid = 1'b1;
    tick();
    bus_i.in_valid = 1'b0;
    got = 0;
    while (!bus_i.out_valid && got < 20) begin
      tick();
      got++;
    end
    chk("hold_latency", 32'(got), 32'd4);
    for (int i = 0; i < 10; i++) begin
      if (i == 4) begin
        bus_i.a        = 16'hAAAA;
        bus_i.b        = 16'h1111;
        bus_i.in_valid = 1'b1;
      end
      if (i == 6) bus_i.in_valid = 1'b0;
      tick();
      chk("hold_diff", 32'(bus_i.diff), 32'h1200);
      chk("hold_in_ready", 32'(bus_i.in_ready), 32'd0);
      chk("hold_out_valid", 32'(bus_i.out_valid), 32'd1);
    end
    bus_i.out_ready = 1'b1;
    tick();
    bus_i.out_ready = 1'b0;
    chk("hold_release_valid", 32'(bus_i.out_valid), 32'd0);
    chk("hold_release_ready", 32'(bus_i.in_ready), 32'd1);

    // Reset during the second RUN cycle aborts the operation.
    bus_i.a        = 16'hFFFF;
    bus_i.b        = 16'h0F0F;
    bus_i.in_valid = 1'b1;
    tick();
    bus_i.in_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", 32'(bus_i.out_valid), 32'd0);
    chk("abort_in_ready", 32'(bus_i.in_ready), 32'd1);
    tick();
    rst_n = 1'b1;
    run_op(16'h0005, 16'h0003, 16'h0002, 1'b0, 1'b0);

    // Back-to-back with in_valid and out_ready held high.
    va[0] = 16'h1234; vb[0] = 16'h4321;
    va[1] = 16'hFFFF; vb[1] = 16'h0001;
    va[2] = 16'h0100; vb[2] = 16'h00FF;
    va[3] = 16'h8000; vb[3] = 16'h8000;
    got  = 0;
    cyc  = 0;
    last = 0;
    bus_i.a         = va[0];
    bus_i.b         = vb[0];
    bus_i.in_valid  = 1'b1;
    bus_i.out_ready = 1'b1;
    while (got < 4 && cyc < 100) begin
      tick();
      cyc++;
      if (bus_i.out_valid) begin
        ref_res = {1'b0, va[got]} - {1'b0, vb[got]};
        chk("b2b_diff", 32'(bus_i.diff), 32'(ref_res[15:0]));
        chk("b2b_borrow", 32'(bus_i.borrow), 32'(ref_res[16]));
        chk("b2b_period", 32'(cyc - last), (got == 0) ? 32'd5 : 32'd6);
        last = cyc;
        got++;
        if (got < 4) begin
          bus_i.a = va[got];
          bus_i.b = vb[got];
        end else begin
          bus_i.in_valid = 1'b0;
        end
      end
    end
    chk("b2b_count", 32'(got), 32'd4);
    bus_i.in_valid  = 1'b0;
    bus_i.out_ready = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
